// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the round-robin UART TX arbiter and the shared transmitter.
// The arbiter connects through the slave modport; client logic and the transmitter use the master side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   i_req_valid;
    logic [NUM_REQ*8-1:0] i_req_data;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [ID_W-1:0]      o_grant_id;
    logic                 i_peer_busy;
    logic                 o_tx_start;
    logic [7:0]           o_tx_data;
    logic                 i_tx_done;
    logic                 o_busy;
    logic                 o_timeout;

    modport slave (
        input  i_req_valid, i_req_data, i_peer_busy, i_tx_done,
        output o_req_ready, o_grant_id, o_tx_start, o_tx_data, o_busy, o_timeout
    );

    modport master (
        output i_req_valid, i_req_data, i_peer_busy, i_tx_done,
        input  o_req_ready, o_grant_id, o_tx_start, o_tx_data, o_busy, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with a one-cycle start pulse, done-pulse completion and an optional completion timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic             i_clk,
    input  logic             i_aresetn,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TERM_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic                TO_EN    = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]    TERM_CNT = CNT_W'(TERM_I);
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]     PTR_RST  = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t             state_r,   state_s;
    logic [ID_W-1:0]    ptr_r,     ptr_s;
    logic [CNT_W-1:0]   cnt_r,     cnt_s;
    logic [NUM_REQ-1:0] ready_r,   ready_s;
    logic [ID_W-1:0]    grant_r,   grant_s;
    logic               start_r,   start_s;
    logic [7:0]         data_r,    data_s;
    logic               busy_r,    busy_s;
    logic               timeout_r, timeout_s;

    logic               found_s;
    logic [ID_W-1:0]    winner_s;
    logic [7:0]         winner_data_s;
    logic               term_s;

    // Round-robin search: first valid requester after the pointer, modulo NUM_REQ
    always_comb begin
        found_s       = 1'b0;
        winner_s      = ptr_r;
        winner_data_s = 8'h00;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found_s && bus.i_req_valid[(int'(ptr_r) + i) % NUM_REQ]) begin
                found_s       = 1'b1;
                winner_s      = ID_W'((int'(ptr_r) + i) % NUM_REQ);
                winner_data_s = bus.i_req_data[((int'(ptr_r) + i) % NUM_REQ) * 8 +: 8];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        ready_s   = {NUM_REQ{1'b0}};
        grant_s   = grant_r;
        start_s   = 1'b0;
        data_s    = data_r;
        timeout_s = 1'b0;
        busy_s    = 1'b0;
        term_s    = TO_EN && (cnt_r == TERM_CNT);
        case (state_r)
            ST_IDLE: begin
                if (!bus.i_peer_busy && found_s) begin
                    state_s = ST_GRANT;
                    ready_s = ONE_HOT0 << winner_s;
                    grant_s = winner_s;
                    ptr_s   = winner_s;
                    data_s  = winner_data_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_s = ST_START;
                start_s = 1'b1;
            end
            ST_START: begin
                state_s = ST_WAIT;
                cnt_s   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                // done has priority over a terminal count in the same cycle
                if (bus.i_tx_done) begin
                    state_s = ST_IDLE;
                end else if (term_s) begin
                    state_s   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, pointer, counter and output registers
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_r   <= ST_IDLE;
            ptr_r     <= PTR_RST;
            cnt_r     <= {CNT_W{1'b0}};
            ready_r   <= {NUM_REQ{1'b0}};
            grant_r   <= {ID_W{1'b0}};
            start_r   <= 1'b0;
            data_r    <= 8'h00;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            ready_r   <= ready_s;
            grant_r   <= grant_s;
            start_r   <= start_s;
            data_r    <= data_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
        end
    end

    assign bus.o_req_ready = ready_r;
    assign bus.o_grant_id  = grant_r;
    assign bus.o_tx_start  = start_r;
    assign bus.o_tx_data   = data_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_timeout   = timeout_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    int           checks = 0;
    int           errors = 0;
    int           ptr_m  = N - 1;
    logic [N-1:0] pend;
    logic [7:0]   dat [N];

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk     (clk),
        .i_aresetn (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec rule: first pending index after the pointer, modulo N
    function automatic int pick(input int ptr, input logic [N-1:0] m);
        for (int i = 1; i <= N; i++) begin
            if (m[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.i_req_valid = pend;
        for (int i = 0; i < N; i++) bus.i_req_data[i*8 +: 8] = dat[i];
    endtask

    task automatic arm(input int i);
        if (!pend[i]) begin
            pend[i] = 1'b1;
            dat[i]  = 8'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.o_req_ready), 32'd0);
        check({tag, "_gid"},   32'(bus.o_grant_id),  32'd0);
        check({tag, "_start"}, 32'(bus.o_tx_start),  32'd0);
        check({tag, "_data"},  32'(bus.o_tx_data),   32'd0);
        check({tag, "_busy"},  32'(bus.o_busy),      32'd0);
        check({tag, "_tmo"},   32'(bus.o_timeout),   32'd0);
    endtask

    // One grant/transmit round starting in an IDLE cycle.
    // wmode: 0 = done j cycles after start, 1 = no done (timeout), 2 = reset mid-WAIT
    // rearm: 0 = none, 1 = random, 2 = every idle requester
    task automatic run_round(input int wmode, input int j, input int busy_cyc,
                             input bit spurious, input int rearm);
        int         w;
        logic [7:0] dw;
        if (pend == '0) arm(int'($urandom_range(N - 1, 0)));
        drive();
        if (busy_cyc > 0) begin
            bus.i_peer_busy = 1'b1;
            for (int k = 0; k < busy_cyc; k++) begin
                step();
                check("pbusy_ready", 32'(bus.o_req_ready), 32'd0);
                check("pbusy_start", 32'(bus.o_tx_start),  32'd0);
                check("pbusy_busy",  32'(bus.o_busy),      32'd0);
            end
            bus.i_peer_busy = 1'b0;
        end
        bus.i_tx_done = spurious;
        w  = pick(ptr_m, pend);
        dw = dat[w];
        step();
        bus.i_tx_done = 1'b0;
        check("grant_ready", 32'(bus.o_req_ready), 32'd1 << w);
        check("grant_id",    32'(bus.o_grant_id),  32'(w));
        check("grant_busy",  32'(bus.o_busy),      32'd1);
        check("grant_start", 32'(bus.o_tx_start),  32'd0);
        check("grant_tmo",   32'(bus.o_timeout),   32'd0);
        ptr_m = w;
        step();
        check("start_pulse", 32'(bus.o_tx_start),  32'd1);
        check("start_data",  32'(bus.o_tx_data),   32'(dw));
        check("start_ready", 32'(bus.o_req_ready), 32'd0);
        pend[w] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rearm == 2 || (rearm == 1 && $urandom_range(1, 0) == 1)) arm(i);
        end
        drive();
        bus.i_tx_done = spurious;
        if (wmode == 0) begin
            for (int k = 1; k <= j; k++) begin
                step();
                bus.i_tx_done = 1'b0;
                check("wait_busy",  32'(bus.o_busy),     32'd1);
                check("wait_start", 32'(bus.o_tx_start), 32'd0);
                check("wait_data",  32'(bus.o_tx_data),  32'(dw));
                check("wait_tmo",   32'(bus.o_timeout),  32'd0);
            end
            bus.i_tx_done = 1'b1;
            step();
            bus.i_tx_done = 1'b0;
            check("done_idle", 32'(bus.o_busy),    32'd0);
            check("done_tmo",  32'(bus.o_timeout), 32'd0);
        end else if (wmode == 1) begin
            for (int k = 1; k <= TO; k++) begin
                step();
                bus.i_tx_done = 1'b0;
                check("to_wait_busy", 32'(bus.o_busy),    32'd1);
                check("to_wait_tmo",  32'(bus.o_timeout), 32'd0);
            end
            step();
            check("to_pulse", 32'(bus.o_timeout), 32'd1);
            check("to_idle",  32'(bus.o_busy),    32'd0);
        end else begin
            repeat (5) step();
            bus.i_tx_done = 1'b0;
            rst_n = 1'b0;
            #1;
            check_all_zero("rst_mid");
            pend = '0;
            arm(0);
            arm(1);
            arm(3);
            drive();
            for (int k = 0; k < 3; k++) begin
                step();
                check("rst_hold_start", 32'(bus.o_tx_start), 32'd0);
                check("rst_hold_busy",  32'(bus.o_busy),     32'd0);
            end
            rst_n = 1'b1;
            ptr_m = N - 1;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        pend            = '0;
        for (int i = 0; i < N; i++) dat[i] = 8'h00;
        bus.i_peer_busy = 1'b0;
        bus.i_tx_done   = 1'b0;
        drive();
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_busy",  32'(bus.o_busy),      32'd0);
        check("idle_ready", 32'(bus.o_req_ready), 32'd0);

        // all requesters valid continuously: order 0,1,2,3,0,1
        for (int i = 0; i < N; i++) arm(i);
        for (int r = 0; r < 6; r++) run_round(0, int'($urandom_range(8, 1)), 0, 1'b0, 2);
        for (int r = 0; r < N; r++) run_round(0, 2, 0, 1'b0, 0);

        // single requester 2 with 8'hA5, done 10 cycles after start
        pend   = '0;
        pend[2] = 1'b1;
        dat[2] = 8'hA5;
        run_round(0, 10, 0, 1'b0, 0);

        // peer busy for 50 cycles with requester 1 waiting
        arm(1);
        run_round(0, 5, 50, 1'b0, 0);

        // timeout, then done exactly on the terminal cycle with spurious done pulses
        arm(3);
        run_round(1, 0, 0, 1'b0, 1);
        run_round(0, TO, 0, 1'b1, 1);

        for (int r = 0; r < 40; r++) begin
            int sel;
            sel = int'($urandom_range(9, 0));
            if (sel == 0)      run_round(1, 0, 0, 1'($urandom_range(1, 0)), 1);
            else if (sel == 1) run_round(0, TO, 0, 1'($urandom_range(1, 0)), 1);
            else run_round(0, int'($urandom_range(15, 1)),
                           (sel == 2) ? int'($urandom_range(5, 1)) : 0,
                           1'($urandom_range(1, 0)), 1);
        end

        // drain, then reset mid-WAIT; first grant after release goes to requester 0
        while (pend != '0) run_round(0, 1, 0, 1'b0, 0);
        pend[2] = 1'b1;
        dat[2]  = 8'h3C;
        run_round(2, 0, 0, 1'b0, 0);
        run_round(0, 4, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
